// File: rtl/io_read_predication_ab_pkg.sv
// Shared constants and helpers for the I/O read predication slice.
package io_read_predication_ab_pkg;

  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/io_read_predication_ab_if.sv
// Operand-side I/O read bus: address from stage 1, port flags in, predication out.
interface io_read_predication_ab_if #(
  parameter int ADDR_WIDTH         = 10,
  parameter int IO_READ_PORT_COUNT = 4
);
  logic [ADDR_WIDTH-1:0]         addr_in;
  logic [IO_READ_PORT_COUNT-1:0] IO_read_EF;
  logic                          cancel;
  logic                          IO_ready;
  logic                          IO_read_hit;
  logic [IO_READ_PORT_COUNT-1:0] IO_read_rden;

  modport slave (
    input  addr_in, IO_read_EF, cancel,
    output IO_ready, IO_read_hit, IO_read_rden
  );

  modport master (
    output addr_in, IO_read_EF, cancel,
    input  IO_ready, IO_read_hit, IO_read_rden
  );
endinterface

// File: rtl/io_read_predication_ab_addr_dec.sv
// Address_Decoder: flags addresses in [ADDR_BASE, ADDR_BASE+ADDR_COUNT),
// optionally registered.
module Address_Decoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_COUNT = 1,
  parameter bit REGISTERED = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o
);
  // One extra bit so BASE+COUNT may reach 2**ADDR_WIDTH without wrapping.
  localparam logic [ADDR_WIDTH:0] LO = (ADDR_WIDTH+1)'(ADDR_BASE);
  localparam logic [ADDR_WIDTH:0] HI = (ADDR_WIDTH+1)'(ADDR_BASE + ADDR_COUNT);

  logic hit_d;

  // Window compare on the zero-extended address.
  always_comb begin
    hit_d = ({1'b0, addr_i} >= LO) && ({1'b0, addr_i} < HI);
  end

  if (REGISTERED) begin : g_reg
    logic hit_q;
    // Pipeline register for the hit flag.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hit_q <= 1'b0;
      end else begin
        hit_q <= hit_d;
      end
    end
    assign hit_o = hit_q;
  end else begin : g_comb
    assign hit_o = hit_d;
  end
endmodule

// File: rtl/io_read_predication_ab_ef_mask.sv
// io_port_ef_mask: per-port saturating down-counter that holds a port
// "empty" for a few cycles after it is read, until its EF catches up.
module io_port_ef_mask
  import io_read_predication_ab_pkg::*;
#(
  parameter int MASK_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  output logic mask_o
);
  localparam int CNT_W = (clog2(MASK_CYCLES + 1) < 1) ? 1 : clog2(MASK_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on a read of this port, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MASK_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mask_o = (cnt_q != '0);
endmodule

// File: rtl/io_read_predication_ab.sv
// Stage 1-3 I/O read predication for one A/B operand memory: decodes the
// I/O window, samples the port EF flag, and issues a one-hot read enable.
module io_read_predication_ab
  import io_read_predication_ab_pkg::*;
#(
  parameter int ADDR_WIDTH              = 10,
  parameter int IO_READ_PORT_COUNT      = 4,
  parameter int IO_READ_PORT_BASE_ADDR  = 1020,
  parameter int IO_READ_PORT_ADDR_WIDTH = 2,
  parameter int EF_MASK_CYCLES          = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  io_read_predication_ab_if.slave bus
);
  localparam int IW = IO_READ_PORT_ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(IO_READ_PORT_BASE_ADDR);

  logic                          hit_s2_q;
  logic [IW-1:0]                 idx_s2_d;
  logic [IW-1:0]                 idx_s2_q;
  logic                          hit_s3_d;
  logic                          hit_s3_q;
  logic [IW-1:0]                 idx_s3_d;
  logic [IW-1:0]                 idx_s3_q;
  logic                          ready_s3_d;
  logic                          ready_s3_q;
  logic [IO_READ_PORT_COUNT-1:0] cnt_mask_s;
  logic [IO_READ_PORT_COUNT-1:0] mask_s;
  logic [IO_READ_PORT_COUNT-1:0] rden_s;

  // Stage-1 window decode, registered into stage 2.
  Address_Decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BASE  (IO_READ_PORT_BASE_ADDR),
    .ADDR_COUNT (IO_READ_PORT_COUNT),
    .REGISTERED (TRUE)
  ) u_addr_dec (
    .clock  (clock),
    .reset  (reset),
    .addr_i (bus.addr_in),
    .hit_o  (hit_s2_q)
  );

  // Port index: full-width subtract (BASE may be unaligned), then truncate.
  always_comb begin
    idx_s2_d = IW'(bus.addr_in - BASE_A);
  end

  // Stage 1 -> 2 index register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_s2_q <= '0;
    end else begin
      idx_s2_q <= idx_s2_d;
    end
  end

  // Stage-2 readiness: a port read this very cycle counts as masked too.
  always_comb begin
    hit_s3_d   = hit_s2_q;
    idx_s3_d   = idx_s2_q;
    ready_s3_d = !hit_s2_q || (bus.IO_read_EF[idx_s2_q] && !mask_s[idx_s2_q]);
  end

  // Stage 2 -> 3 register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_s3_q   <= 1'b0;
      idx_s3_q   <= '0;
      ready_s3_q <= 1'b1;
    end else begin
      hit_s3_q   <= hit_s3_d;
      idx_s3_q   <= idx_s3_d;
      ready_s3_q <= ready_s3_d;
    end
  end

  // One-hot read enable, annulled by a stage-3 cancel.
  always_comb begin
    rden_s = '0;
    if (hit_s3_q && ready_s3_q && !bus.cancel) begin
      rden_s[idx_s3_q] = 1'b1;
    end else begin
      rden_s = '0;
    end
  end

  if (EF_MASK_CYCLES > 0) begin : g_masking
    for (genvar p = 0; p < IO_READ_PORT_COUNT; p++) begin : g_port
      io_port_ef_mask #(
        .MASK_CYCLES (EF_MASK_CYCLES)
      ) u_mask (
        .clock  (clock),
        .reset  (reset),
        .load_i (rden_s[p]),
        .mask_o (cnt_mask_s[p])
      );
    end
  end else begin : g_no_masking
    assign cnt_mask_s = '0;
  end

  assign mask_s           = cnt_mask_s | rden_s;
  assign bus.IO_ready     = ready_s3_q;
  assign bus.IO_read_hit  = hit_s3_q;
  assign bus.IO_read_rden = rden_s;
endmodule

// File: tb/tb_io_read_predication_ab.sv
// Directed bench for io_read_predication_ab with an expectation queue.
module tb_io_read_predication_ab;

  typedef struct {
    int         cyc;
    logic       rdy;
    logic       hit;
    logic [3:0] rden;
    string      tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  exp_t sb[$];
  exp_t cur;
  logic [1:0] mcnt [4];

  io_read_predication_ab_if bus ();

  io_read_predication_ab dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected outputs for the address driven now appear two cycles later.
  task automatic step(input logic [9:0] a, input logic [3:0] ef, input logic c,
                      input logic er, input logic eh, input logic [3:0] erd,
                      input string tag);
    exp_t e;
    e.cyc  = cyc + 2;
    e.rdy  = er;
    e.hit  = eh;
    e.rden = erd;
    e.tag  = tag;
    sb.push_back(e);
    bus.addr_in    = a;
    bus.IO_read_EF = ef;
    bus.cancel     = c;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard pop/compare, plus a read-while-masked monitor.
  always @(negedge clock) begin
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      cur = sb.pop_front();
      chk({cur.tag, ".ready"}, {3'b000, bus.IO_ready}, {3'b000, cur.rdy});
      chk({cur.tag, ".hit"}, {3'b000, bus.IO_read_hit}, {3'b000, cur.hit});
      chk({cur.tag, ".rden"}, bus.IO_read_rden, cur.rden);
    end
    for (int p = 0; p < 4; p++) begin
      if (reset) begin
        mcnt[p] <= 2'd0;
      end else if (bus.IO_read_rden[p]) begin
        chk($sformatf("reread_while_masked.p%0d", p), {2'b00, mcnt[p]}, 4'd0);
        mcnt[p] <= 2'd2;
      end else if (mcnt[p] != 2'd0) begin
        mcnt[p] <= mcnt[p] - 2'd1;
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.addr_in    = 10'd0;
    bus.IO_read_EF = 4'b0000;
    bus.cancel     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.ready", {3'b000, bus.IO_ready}, 4'd1);
    chk("rst.hit", {3'b000, bus.IO_read_hit}, 4'd0);
    chk("rst.rden", bus.IO_read_rden, 4'd0);
    // I/O address under reset must not leak through.
    bus.addr_in    = 10'd1022;
    bus.IO_read_EF = 4'b1111;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hold.ready", {3'b000, bus.IO_ready}, 4'd1);
    chk("rst_hold.hit", {3'b000, bus.IO_read_hit}, 4'd0);
    chk("rst_hold.rden", bus.IO_read_rden, 4'd0);
    bus.addr_in = 10'd0;
    reset       = 1'b0;

    // Non-I/O addresses, including just below the window.
    step(10'd5,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "nonio5");
    step(10'd1019, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "below_base");
    step(10'd0,    4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");

    // Port 2 with data: single rden pulse, counter loaded to 2.
    step(10'd1022, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0100, "rd2");
    step(10'd0,    4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd0,    4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    chk("cnt2_loaded", {2'b00, dut.g_masking.g_port[2].u_mask.cnt_q}, 4'd2);

    // Port 1 empty: not ready, no rden, no counter load.
    step(10'd1021, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, "ef1_empty");
    step(10'd0,    4'b1101, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    chk("cnt1_idle", {2'b00, dut.g_masking.g_port[1].u_mask.cnt_q}, 4'd0);

    // Port 3 back-to-back: second masked, access after the mask window is ready.
    step(10'd1023, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b1000, "b2b_first");
    step(10'd1023, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, "b2b_masked");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd1023, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b1000, "b2b_later");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");

    // Port 0 cancelled in stage 3: ready reported, no rden, no mask.
    step(10'd1020, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000, "cancel0");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd0,    4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, "idle");
    chk("cnt0_not_loaded", {2'b00, dut.g_masking.g_port[0].u_mask.cnt_q}, 4'd0);
    step(10'd1020, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, "after_cancel");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");

    // Drain, then reset with a hit sitting in stage 2.
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    bus.addr_in = 10'd1022;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst.ready", {3'b000, bus.IO_ready}, 4'd1);
    chk("midrst.hit", {3'b000, bus.IO_read_hit}, 4'd0);
    chk("midrst.rden", bus.IO_read_rden, 4'd0);
    bus.addr_in = 10'd1023;
    @(posedge clock);
    #1;
    chk("midrst_hold.hit", {3'b000, bus.IO_read_hit}, 4'd0);
    chk("midrst_hold.rden", bus.IO_read_rden, 4'd0);
    reset = 1'b0;

    step(10'd1022, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0100, "post_rst");
    step(10'd1021, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0010, "post_rst2");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");
    step(10'd0,    4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, "idle");

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", (sb.size() == 0) ? 4'd1 : 4'd0, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
